// File: rtl/fakeram_pkg.sv
// Shared types and parameter helpers for the fakeram_1rwnr_sram SRAM model.
package fakeram_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    function automatic int lane_width(input int bits, input int lanes);
        return bits / lanes;
    endfunction

    function automatic bit params_ok(input int bits, input int depth, input int aw,
                                     input int nr, input int lanes);
        return (aw == $clog2(depth)) && (lanes > 0) && (bits % lanes == 0)
               && (nr >= 1) && (nr <= 4);
    endfunction

endpackage

// File: rtl/fakeram_rport.sv
// One registered read port; FAKERAM_RDW_BYPASS_EN selects write-first on a same-address write.
module fakeram_rport #(
    parameter int BITS       = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BITS-1:0]       rd_word,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BITS-1:0]       wr_word,
    output logic [BITS-1:0]       rd_data
);

    logic [BITS-1:0] next_word;

`ifdef FAKERAM_RDW_BYPASS_EN
    assign next_word = (wr_en && (wr_addr == addr)) ? wr_word : rd_word;
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_word};
    assign next_word = rd_word;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (en) begin
            rd_data <= next_word;
        end
    end

endmodule

// File: rtl/fakeram_1rwnr_sram.sv
// Behavioural 1RW + NUM_R read-only SRAM with post-reset clear sweep.
// Optional: FAKERAM_RDW_BYPASS_EN (R-port write-first); SYNTHESIS zeroes out-of-range reads.
module fakeram_1rwnr_sram
    import fakeram_pkg::*;
#(
    parameter int BITS        = 64,
    parameter int WORD_DEPTH  = 64,
    parameter int ADDR_WIDTH  = 6,
    parameter int NUM_R       = 1,
    parameter int WMASK_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        init_done,
    input  logic                        rw0_ce_in,
    input  logic                        rw0_we_in,
    input  logic [WMASK_WIDTH-1:0]      rw0_wmask_in,
    input  logic [ADDR_WIDTH-1:0]       rw0_addr_in,
    input  logic [BITS-1:0]             rw0_wd_in,
    output logic [BITS-1:0]             rw0_rd_out,
    input  logic [NUM_R-1:0]            r_ce_in,
    input  logic [NUM_R*ADDR_WIDTH-1:0] r_addr_in,
    output logic [NUM_R*BITS-1:0]       r_rd_out
);

    localparam int LANE = lane_width(BITS, WMASK_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
`ifdef SYNTHESIS
    localparam logic [BITS-1:0] OOR_WORD = '0;
`else
    localparam logic [BITS-1:0] OOR_WORD = 'x;
`endif

    if (!params_ok(BITS, WORD_DEPTH, ADDR_WIDTH, NUM_R, WMASK_WIDTH)) begin : g_param_check
        $error("fakeram_1rwnr_sram: inconsistent BITS/WORD_DEPTH/ADDR_WIDTH/NUM_R/WMASK_WIDTH");
    end

    logic [BITS-1:0] mem [WORD_DEPTH];

    state_e                state, state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  clear_we;
    logic                  ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clear_we   = 1'b0;
        ready      = 1'b0;
        case (state)
            CLEAR: begin
                clear_we = 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_next = READY;
                end
            end
            READY: ready = 1'b1;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (clear_we && (clr_cnt != LAST_ADDR)) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    assign init_done = (state == READY);

    logic            rw_in_range;
    logic [BITS-1:0] rw_word;
    logic [BITS-1:0] merged;
    logic            user_we;

    assign rw_in_range = (rw0_addr_in <= LAST_ADDR);
    assign rw_word     = rw_in_range ? mem[rw0_addr_in] : OOR_WORD;
    assign user_we     = ready && !rst && rw0_ce_in && rw0_we_in && rw_in_range;

    always_comb begin
        merged = rw_word;
        for (int unsigned j = 0; j < WMASK_WIDTH; j++) begin
            if (rw0_wmask_in[j]) begin
                merged[j*LANE +: LANE] = rw0_wd_in[j*LANE +: LANE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clear_we) begin
                mem[clr_cnt] <= '0;
            end else if (user_we) begin
                mem[rw0_addr_in] <= merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rw0_rd_out <= '0;
        end else if (ready && rw0_ce_in && !rw0_we_in) begin
            rw0_rd_out <= rw_word;
        end
    end

    for (genvar k = 0; k < NUM_R; k++) begin : g_rport
        logic [ADDR_WIDTH-1:0] addr_k;
        logic [BITS-1:0]       word_k;

        assign addr_k = r_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign word_k = (addr_k <= LAST_ADDR) ? mem[addr_k] : OOR_WORD;

        fakeram_rport #(
            .BITS       (BITS),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_rport (
            .clk     (clk),
            .rst     (rst),
            .en      (ready && r_ce_in[k]),
            .addr    (addr_k),
            .rd_word (word_k),
            .wr_en   (user_we),
            .wr_addr (rw0_addr_in),
            .wr_word (merged),
            .rd_data (r_rd_out[k*BITS +: BITS])
        );
    end

endmodule

// File: tb/tb_fakeram_1rwnr_sram.sv
// Self-checking bench for fakeram_1rwnr_sram (NUM_R=3): directed steps plus random traffic vs. a word-level model.
module tb_fakeram_1rwnr_sram;

    localparam int BITS  = 64;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int NR    = 3;
    localparam int NL    = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 init_done;
    logic                 rw0_ce_in;
    logic                 rw0_we_in;
    logic [NL-1:0]        rw0_wmask_in;
    logic [AW-1:0]        rw0_addr_in;
    logic [BITS-1:0]      rw0_wd_in;
    logic [BITS-1:0]      rw0_rd_out;
    logic [NR-1:0]        r_ce_in;
    logic [NR*AW-1:0]     r_addr_in;
    logic [NR*BITS-1:0]   r_rd_out;

    always #5 clk = ~clk;

    fakeram_1rwnr_sram #(
        .BITS        (BITS),
        .WORD_DEPTH  (DEPTH),
        .ADDR_WIDTH  (AW),
        .NUM_R       (NR),
        .WMASK_WIDTH (NL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .init_done    (init_done),
        .rw0_ce_in    (rw0_ce_in),
        .rw0_we_in    (rw0_we_in),
        .rw0_wmask_in (rw0_wmask_in),
        .rw0_addr_in  (rw0_addr_in),
        .rw0_wd_in    (rw0_wd_in),
        .rw0_rd_out   (rw0_rd_out),
        .r_ce_in      (r_ce_in),
        .r_addr_in    (r_addr_in),
        .r_rd_out     (r_rd_out)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: word array plus a countdown standing in for the clear sweep.
    logic [BITS-1:0] model_mem [DEPTH];
    int              clear_left = 0;
    logic            exp_init = 1'b0;
    logic [BITS-1:0] exp_rw = '0;
    logic [BITS-1:0] exp_r [NR];

    task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [BITS-1:0] expand(input logic [NL-1:0] m);
        logic [BITS-1:0] r;
        r = '0;
        for (int j = 0; j < NL; j++) if (m[j]) r[j*8 +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic tick();
        int              a;
        int              ra [NR];
        logic [BITS-1:0] old_rw;
        logic [BITS-1:0] old_r [NR];
        logic [BITS-1:0] m;
        if (rst) begin
            clear_left = DEPTH;
            exp_init   = 1'b0;
            exp_rw     = '0;
            for (int k = 0; k < NR; k++) exp_r[k] = '0;
        end else if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
                exp_init = 1'b1;
            end
        end else begin
            a      = int'(rw0_addr_in);
            old_rw = model_mem[a];
            for (int k = 0; k < NR; k++) begin
                ra[k]    = int'(r_addr_in[k*AW +: AW]);
                old_r[k] = model_mem[ra[k]];
            end
            if (rw0_ce_in && rw0_we_in) begin
                m = expand(rw0_wmask_in);
                model_mem[a] = (old_rw & ~m) | (rw0_wd_in & m);
            end
            if (rw0_ce_in && !rw0_we_in) exp_rw = old_rw;
            for (int k = 0; k < NR; k++) begin
                if (r_ce_in[k]) begin
`ifdef FAKERAM_RDW_BYPASS_EN
                    exp_r[k] = model_mem[ra[k]];
`else
                    exp_r[k] = old_r[k];
`endif
                end
            end
        end
        @(posedge clk);
        #1;
        check("init_done", BITS'(init_done), BITS'(exp_init));
        check("rw0_rd", rw0_rd_out, exp_rw);
        for (int k = 0; k < NR; k++) check($sformatf("r_rd[%0d]", k), r_rd_out[k*BITS +: BITS], exp_r[k]);
    endtask

    task automatic idle();
        rw0_ce_in    = 1'b0;
        rw0_we_in    = 1'b0;
        rw0_wmask_in = '0;
        rw0_addr_in  = '0;
        rw0_wd_in    = '0;
        r_ce_in      = '0;
        r_addr_in    = '0;
    endtask

    task automatic rw_write(input int a, input logic [BITS-1:0] d, input logic [NL-1:0] m);
        idle();
        rw0_ce_in = 1'b1; rw0_we_in = 1'b1; rw0_wmask_in = m;
        rw0_addr_in = AW'(a); rw0_wd_in = d;
    endtask

    task automatic rw_read(input int a);
        idle();
        rw0_ce_in = 1'b1; rw0_addr_in = AW'(a);
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!init_done && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        logic [BITS-1:0] rdw_exp;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 1: clear sweep length and cleared contents
        wait_init(cyc);
        check("clear_len", BITS'(cyc), BITS'(DEPTH));
        rw_read(0);  tick(); check("clr_addr0", rw0_rd_out, '0);
        rw_read(31); tick(); check("clr_addr31", rw0_rd_out, '0);
        rw_read(63); tick(); check("clr_addr63", rw0_rd_out, '0);

        // 2: masked write
        rw_write(5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF); tick();
        rw_write(5, 64'h0, 8'h01); tick();
        rw_read(5); tick();
        check("masked_write", rw0_rd_out, 64'hFFFF_FFFF_FFFF_FF00);

        // 3: parallel reads on three ports
        rw_write(1, 64'h11, 8'hFF); tick();
        rw_write(2, 64'h22, 8'hFF); tick();
        rw_write(3, 64'h33, 8'hFF); tick();
        idle();
        r_ce_in = 3'b111;
        r_addr_in = {AW'(3), AW'(2), AW'(1)};
        tick();
        check("par_r0", r_rd_out[0*BITS +: BITS], 64'h11);
        check("par_r1", r_rd_out[1*BITS +: BITS], 64'h22);
        check("par_r2", r_rd_out[2*BITS +: BITS], 64'h33);

        // 4: read-during-write on R port 0
        rw_write(7, 64'hAA, 8'hFF); tick();
        rw_write(7, 64'hBB, 8'hFF);
        r_ce_in[0] = 1'b1; r_addr_in[0 +: AW] = AW'(7);
        tick();
`ifdef FAKERAM_RDW_BYPASS_EN
        rdw_exp = 64'hBB;
`else
        rdw_exp = 64'hAA;
`endif
        check("rdw_r0", r_rd_out[0 +: BITS], rdw_exp);

        // 5: hold on ce=0
        idle();
        r_ce_in[1] = 1'b1; r_addr_in[AW +: AW] = AW'(3);
        tick();
        rw_write(3, 64'h44, 8'hFF); tick();
        check("hold_r1", r_rd_out[BITS +: BITS], 64'h33);

        // random traffic over a narrow address window to force collisions
        for (int i = 0; i < 300; i++) begin
            rw0_ce_in    = 1'($urandom);
            rw0_we_in    = 1'($urandom);
            rw0_wmask_in = NL'($urandom);
            rw0_addr_in  = AW'($urandom_range(0, 15));
            rw0_wd_in    = {$urandom, $urandom};
            r_ce_in      = NR'($urandom);
            for (int k = 0; k < NR; k++) r_addr_in[k*AW +: AW] = AW'($urandom_range(0, 15));
            tick();
        end

        // 6: reset during the clear sweep, with writes attempted while clearing
        rst = 1'b1; idle(); tick(); rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rw_write($urandom_range(0, 63), {$urandom, $urandom}, 8'hFF);
            r_ce_in = '1;
            tick();
        end
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < DEPTH + 10 && !init_done; i++) begin
            rw_write($urandom_range(0, 63), {$urandom, $urandom}, 8'hFF);
            r_ce_in = '1;
            if (i == 0) cyc = 0;
            tick();
            cyc++;
        end
        check("reclear_len", BITS'(cyc), BITS'(DEPTH));
        for (int a = 0; a < DEPTH; a++) begin
            rw_read(a);
            tick();
            check("reclear_zero", rw0_rd_out, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fakeram_1rwnr_sram.md
# fakeram_1rwnr_sram

- Behavioural, synthesizable multi-port SRAM model for the nangate45 liteeth SRAM flow.
- Generalises the fixed 1RW+1R 64x64 macro: width, depth, read-port count and write-mask granularity are parameters.
- Adds a post-reset clear sequencer and defined read-during-write behaviour.
- Used in RTL simulation and FPGA prototyping wherever a fakeram macro is instantiated as a blackbox for the ASIC flow.

## Interface
- BITS, 64, data width per word
- WORD_DEPTH, 64, number of words
- ADDR_WIDTH, 6, address width; must equal $clog2(WORD_DEPTH)
- NUM_R, 1, number of read-only ports (1..4)
- WMASK_WIDTH, 8, write-mask lanes; BITS must be divisible by WMASK_WIDTH
- clk  in  1  single clock for all ports; synchronous, active-high reset
- rst  in  1  synchronous active-high reset; starts the clear sweep
- init_done  out  1  high once the clear sweep completes
- rw0_ce_in  in  1  RW port enable
- rw0_we_in  in  1  write enable; qualified by rw0_ce_in
- rw0_wmask_in  in  WMASK_WIDTH  per-lane write enable
- rw0_addr_in  in  ADDR_WIDTH  RW address
- rw0_wd_in  in  BITS  write data
- rw0_rd_out  out  BITS  RW read data
- r_ce_in  in  NUM_R  per-read-port enable
- r_addr_in  in  NUM_R*ADDR_WIDTH  packed read addresses; port k occupies [k*ADDR_WIDTH +: ADDR_WIDTH]
- r_rd_out  out  NUM_R*BITS  packed read data; port k occupies [k*BITS +: BITS]

## Operation
- FSM states:
  - CLEAR: entered on rst. Writes zero to word clr_cnt each cycle; clr_cnt counts 0..WORD_DEPTH-1. Moves to READY after writing the last word.
  - READY: normal operation. Stays in READY until the next rst.
- Reset values: init_done=0, rw0_rd_out=0, r_rd_out=0, clr_cnt=0, state=CLEAR.
- In CLEAR:
  - All ce inputs are ignored.
  - No user write occurs.
  - Read outputs hold 0.
- Write (READY, ce=1, we=1):
  - Lane j (bits [j*L +: L], where L = BITS/WMASK_WIDTH) is updated only when wmask[j]=1.
  - rw0_rd_out holds its previous value.
- RW read (READY, ce=1, we=0): rw0_rd_out = mem[addr] on the next cycle.
- R-port read (READY, r_ce_in[k]=1): r_rd_out[k] = mem[addr_k] on the next cycle.
  - Any number of ports may read the same address in the same cycle.
- ce=0: the corresponding output holds its last value.
- Out-of-range address (addr ≥ WORD_DEPTH, non-power-of-two depth):
  - Writes are dropped.
  - Reads return all-X in simulation and 0 in synthesis (guarded by SYNTHESIS).
- rst asserted mid-operation, including mid-CLEAR: the sweep restarts at word 0 on the next cycle.
- Read-during-write, R port at the address being written: governed by the Configuration macro.
- Read-during-write, RW port: not applicable, since RW is single-port.

## Timing
- Read latency is 1 cycle on all ports; rd_out is registered.
- The write is visible to a read issued on the following cycle.
- Clear sweep takes exactly WORD_DEPTH cycles after rst deasserts.
- init_done rises in the cycle after the last clear write.
- First accepted access is in the cycle init_done=1.

## Configuration
- FAKERAM_RDW_BYPASS_EN defined: an R port reading the address written in the same cycle returns the new merged data. Masked-off lanes keep their old value.
- Not defined: the R port returns the old (pre-write) data (read-first).

## Structure
- Package fakeram_pkg holds:
  - state enum (CLEAR, READY)
  - localparam helper for lane width
  - elaboration assertions: ADDR_WIDTH/WORD_DEPTH consistency, BITS % WMASK_WIDTH == 0, 1 ≤ NUM_R ≤ 4
- Sub-module fakeram_rport: one registered read port containing the ce/hold register and the bypass mux. Instantiated NUM_R times in a generate loop.
- The top level owns the memory array, the write path with lane merge, and the clear FSM.

## Test plan
1. Reset then wait: rst 1 cycle → init_done=0 for 64 cycles, then 1; RW reads of addr 0, 31 and 63 return 0.
2. Masked write: write 0xFFFF_FFFF_FFFF_FFFF to addr 5, then wmask=8'h01 with wd=0 → read returns 0xFFFF_FFFF_FFFF_FF00.
3. Parallel reads, NUM_R=3: preload addr 1/2/3 with 0x11/0x22/0x33; issue all three reads in one cycle → next cycle the outputs are 0x11/0x22/0x33.
4. Read-during-write: addr 7 holds 0xAA; write 0xBB to addr 7 while R port 0 reads addr 7 → returns 0xBB with the macro, 0xAA without.
5. Hold on ce=0: read addr 3 (0x33), then deassert ce and write addr 3=0x44 → r_rd_out stays 0x33.
6. Mid-clear reset: assert rst at clear cycle 30 → init_done rises exactly 64 cycles after the second rst; writes attempted during CLEAR are absent afterwards.
